// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: pick an owner, issue to memory, wait for completion, respond.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Which requester owns the transaction currently on the memory port.
  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Read data returned to a requester whose read timed out; sliced to the data width at use.
  localparam logic [63:0] ERR_RDATA = '1;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for the WAIT phase. The count is the number of completed
// wait cycles; hit flags the cycle in which the TIMEOUT-th wait cycle elapses.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles from a clear, holding at the last value instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign hit = en && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter serializing instruction fetches and load/stores onto one
// busy/ready memory port, with data priority, a fetch starvation guard and a
// watchdog that aborts transactions whose completion never arrives.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_instr,
  output logic          mem_read_done,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_busy,
  input  logic          mem_ready
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [DW-1:0] ERR_WORD = ERR_RDATA[DW-1:0];

  state_t        state;
  state_t        state_next;
  owner_t        owner;
  logic          we;
  logic          err_flag;
  logic [SW-1:0] streak;
  logic          grant_i;
  logic          any_req;
  logic          is_read;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_hit;

  // A fetch only beats a data request once data has won MAX_D_STREAK times in a row over it.
  assign any_req = i_req || d_req;
  assign grant_i = i_req && (!d_req || (streak == STREAK_MAX));
  assign is_read = (owner == OWN_I) || !we;

  assign timer_clr = (state != WAIT);
  assign timer_en  = (state == WAIT) && !mem_ready;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr),
    .en (timer_en),
    .hit(timer_hit)
  );

  // State register; reset aborts any transaction in flight without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the per-state strobes on both sides of the arbiter.
  always_comb begin
    state_next    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_instr     = 1'b0;
    mem_read_done = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    err           = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_instr = (owner == OWN_I);
        if (!mem_busy) begin
          mem_read   = is_read;
          mem_write  = !is_read;
          state_next = WAIT;
        end
      end
      WAIT: begin
        mem_instr = (owner == OWN_I);
        if (mem_ready || timer_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        mem_instr     = (owner == OWN_I);
        i_done        = (owner == OWN_I);
        d_done        = (owner == OWN_D);
        err           = err_flag;
        mem_read_done = is_read && !err_flag;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winning request at grant time and track the data-over-fetch streak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_I;
      we        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      streak    <= '0;
    end else if ((state == IDLE) && any_req) begin
      if (grant_i) begin
        owner     <= OWN_I;
        we        <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        streak    <= '0;
      end else begin
        owner     <= OWN_D;
        we        <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (i_req && (streak != STREAK_MAX)) begin
          streak <= streak + SW'(1);
        end
      end
    end
  end

  // Capture read data (or the error word on timeout) into the owner's held rdata output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata  <= '0;
      d_rdata  <= '0;
      err_flag <= 1'b0;
    end else if (state == IDLE) begin
      err_flag <= 1'b0;
    end else if (state == WAIT) begin
      if (mem_ready) begin
        if (is_read && (owner == OWN_I)) begin
          i_rdata <= mem_rdata;
        end else if (is_read) begin
          d_rdata <= mem_rdata;
        end
      end else if (timer_hit) begin
        err_flag <= 1'b1;
        if (is_read && (owner == OWN_I)) begin
          i_rdata <= ERR_WORD;
        end else if (is_read) begin
          d_rdata <= ERR_WORD;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_instr;
  logic        mem_read_done;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic        mem_ready;

  int total;
  int bad;

  mem_arbiter #(
    .AW(16),
    .DW(16),
    .MAX_D_STREAK(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_done(i_done),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_done(d_done),
    .d_rdata(d_rdata),
    .err(err),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_instr(mem_instr),
    .mem_read_done(mem_read_done),
    .mem_rdata(mem_rdata),
    .mem_busy(mem_busy),
    .mem_ready(mem_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, drive the inputs just after the edge, then settle before checks.
  task automatic applyStimulus(input logic ir, input logic dr, input logic dwe,
                               input logic busy, input logic rdy, input logic [15:0] rdat);
    @(posedge clk);
    #1;
    i_req     = ir;
    d_req     = dr;
    d_we      = dwe;
    mem_busy  = busy;
    mem_ready = rdy;
    mem_rdata = rdat;
    #1;
  endtask

  logic exp_order [10];
  int   cnt;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_busy  = 1'b0;
    mem_ready = 1'b0;
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reset values
    #3;
    checkOutput("rst_i_done", i_done, 0);
    checkOutput("rst_d_done", d_done, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_instr", mem_instr, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    #9;
    rst = 1'b1;

    // Single fetch, ready at cycle 3
    i_addr = 16'h0040;
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    checkOutput("f_c0_read", mem_read, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    checkOutput("f_c1_read", mem_read, 1);
    checkOutput("f_c1_instr", mem_instr, 1);
    checkOutput("f_c1_addr", mem_addr, 16'h0040);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000);
    checkOutput("f_c2_read", mem_read, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'hBEEF);
    checkOutput("f_c3_done", i_done, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("f_c4_done", i_done, 1);
    checkOutput("f_c4_rdata", i_rdata, 16'hBEEF);
    checkOutput("f_c4_rdone", mem_read_done, 1);
    checkOutput("f_c4_err", err, 0);

    // Data write stalled by mem_busy for three cycles
    d_addr  = 16'h1234;
    d_wdata = 16'h00AA;
    applyStimulus(0, 1, 1, 0, 0, 16'h0000);
    checkOutput("w_c0_write", mem_write, 0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 1, 1, 1, 0, 16'h0000);
      checkOutput("w_busy_write", mem_write, 0);
    end
    applyStimulus(0, 1, 1, 0, 0, 16'h0000);
    checkOutput("w_c4_write", mem_write, 1);
    checkOutput("w_c4_read", mem_read, 0);
    checkOutput("w_c4_instr", mem_instr, 0);
    checkOutput("w_c4_addr", mem_addr, 16'h1234);
    checkOutput("w_c4_wdata", mem_wdata, 16'h00AA);
    applyStimulus(0, 1, 1, 0, 1, 16'h5555);
    checkOutput("w_c5_write", mem_write, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("w_done", d_done, 1);
    checkOutput("w_rdone", mem_read_done, 0);
    checkOutput("w_d_rdata", d_rdata, 16'h0000);
    checkOutput("w_i_rdata", i_rdata, 16'hBEEF);

    // Both requesters held: starvation guard lets a fetch in after four data grants
    i_addr = 16'h0100;
    d_addr = 16'h0200;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1, 1, 0, 0, 0, 16'h0000);
      applyStimulus(1, 1, 0, 0, 0, 16'h0000);
      checkOutput($sformatf("grant%0d_instr", n), mem_instr, exp_order[n]);
      checkOutput($sformatf("grant%0d_read", n), mem_read, 1);
      applyStimulus(1, 1, 0, 0, 1, 16'h1000 + 16'(n));
      applyStimulus(1, 1, 0, 0, 0, 16'h0000);
      checkOutput($sformatf("grant%0d_idone", n), i_done, exp_order[n]);
      checkOutput($sformatf("grant%0d_ddone", n), d_done, !exp_order[n]);
      checkOutput($sformatf("grant%0d_rdata", n),
                  exp_order[n] ? i_rdata : d_rdata, 16'h1000 + 16'(n));
    end

    // Read that never gets mem_ready: watchdog fires 256 cycles after the issue strobe
    d_addr = 16'h2000;
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    checkOutput("to_issue", mem_read, 1);
    cnt = 0;
    do begin
      applyStimulus(0, 1, 0, 0, 0, 16'h0000);
      cnt++;
    end while (!d_done && cnt < 300);
    checkOutput("to_latency", cnt, 256);
    checkOutput("to_err", err, 1);
    checkOutput("to_rdata", d_rdata, 16'hFFFF);
    checkOutput("to_rdone", mem_read_done, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("to_after_err", err, 0);

    // Reset during WAIT aborts silently; a stray ready afterwards is ignored
    d_addr = 16'h3000;
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    rst   = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("rw_done", d_done, 0);
    checkOutput("rw_instr", mem_instr, 0);
    #4;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 16'h7777);
    checkOutput("rw_stray_done", d_done, 0);
    checkOutput("rw_stray_err", err, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("rw_idle_done", d_done, 0);
    checkOutput("rw_idle_read", mem_read, 0);
    checkOutput("rw_rdata", d_rdata, 16'h0000);

    // d_req dropped during WAIT still completes; then nothing is issued
    d_addr = 16'h3000;
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000);
    checkOutput("dr_issue", mem_read, 1);
    checkOutput("dr_addr", mem_addr, 16'h3000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 1, 16'h4242);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("dr_done", d_done, 1);
    checkOutput("dr_rdata", d_rdata, 16'h4242);
    checkOutput("dr_rdone", mem_read_done, 1);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOutput("dr_idle_read", mem_read, 0);
    checkOutput("dr_idle_write", mem_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
